// File: rtl/fifo_byte_reader.sv
// Drains 32-bit words from a show-ahead FIFO and serializes them
// into byte beats on a valid/ready stream, one beat per clock.
module fifo_byte_reader #(
   parameter int word_width = 32,
   parameter int byte_width = 8,
   parameter bit lsb_first  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [word_width-1:0] fifo_data,
   output logic                  fifo_pop,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [byte_width-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic [15:0]           word_count
);

   localparam int N  = word_width / byte_width;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                r_state;
   logic [word_width-1:0] r_shift;
   logic [IW-1:0]         r_idx;

   logic                  w_xfer;
   logic                  w_at_last;
   logic                  w_load;
   logic [word_width-1:0] w_shifted;
   logic [byte_width-1:0] w_load_byte;
   logic [byte_width-1:0] w_next_byte;
   logic [IW-1:0]         w_idx_inc;

   always_comb begin
      w_at_last = (r_idx == LAST_IDX);
      w_xfer    = (r_state == SEND) && m_ready;
      w_load    = !fifo_empty && enable &&
                  ((r_state == IDLE) || (w_xfer && w_at_last));
      w_idx_inc = r_idx + IW'(1);
      w_shifted = lsb_first ? (r_shift >> byte_width)
                            : (r_shift << byte_width);
      // m_data is registered, so the next slice is chosen one edge early
      w_load_byte = lsb_first ? fifo_data[byte_width-1:0]
                              : fifo_data[word_width-1 -: byte_width];
      w_next_byte = lsb_first ? w_shifted[byte_width-1:0]
                              : w_shifted[word_width-1 -: byte_width];
   end

   assign fifo_pop = w_load && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_idx      <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         busy       <= 1'b0;
         word_count <= '0;
      end else begin
         if (w_xfer && w_at_last)
            word_count <= word_count + 16'd1;
         if (w_load) begin
            r_state <= SEND;
            r_shift <= fifo_data;
            r_idx   <= '0;
            m_valid <= 1'b1;
            busy    <= 1'b1;
            m_data  <= w_load_byte;
            m_last  <= (N == 1);
         end else if (w_xfer) begin
            if (w_at_last) begin
               r_state <= IDLE;
               m_valid <= 1'b0;
               busy    <= 1'b0;
               m_last  <= 1'b0;
            end else begin
               r_shift <= w_shifted;
               r_idx   <= w_idx_inc;
               m_data  <= w_next_byte;
               m_last  <= (w_idx_inc == LAST_IDX);
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Bench for fifo_byte_reader: directed scenarios plus a randomized
// run against a queue-based model of the byte stream.
module tb_fifo_byte_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        fifo_empty;
   logic [31:0] fifo_data;
   logic        fifo_pop;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;
   logic        busy;
   logic [15:0] word_count;

   logic        en_b;
   logic        empty_b;
   logic [31:0] data_b;
   logic        pop_b;
   logic        valid_b;
   logic        ready_b;
   logic [7:0]  mdata_b;
   logic        last_b;
   logic        busy_b;
   logic [15:0] count_b;

   always #5 clk = ~clk;

   fifo_byte_reader #(.word_width(32), .byte_width(8), .lsb_first(1'b1)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy), .word_count(word_count)
   );

   fifo_byte_reader #(.word_width(32), .byte_width(8), .lsb_first(1'b0)) dut_msb (
      .clk(clk), .reset(reset), .enable(en_b),
      .fifo_empty(empty_b), .fifo_data(data_b), .fifo_pop(pop_b),
      .m_valid(valid_b), .m_ready(ready_b), .m_data(mdata_b),
      .m_last(last_b), .busy(busy_b), .word_count(count_b)
   );

   typedef struct {
      int         c;
      logic [7:0] d;
      logic       l;
   } beat_t;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   logic [31:0] fq[$];
   beat_t       blog[$];
   int          plog[$];

   logic        s_pop, s_valid, s_last, s_busy;
   logic [7:0]  s_data;
   logic [15:0] s_cnt;

   // One clock: present FIFO head, sample, log, then let the FIFO react to pop
   task automatic cycle();
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
      #1;
      s_pop   = fifo_pop;
      s_valid = m_valid;
      s_data  = m_data;
      s_last  = m_last;
      s_busy  = busy;
      s_cnt   = word_count;
      if (s_pop) plog.push_back(cyc);
      if (s_valid && m_ready) blog.push_back('{cyc, s_data, s_last});
      @(posedge clk);
      if (s_pop && fq.size() != 0) void'(fq.pop_front());
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      fq.delete();
      fq.push_back(32'h12345678);
      fifo_empty = 1'b0;
      fifo_data  = 32'h12345678;
      @(negedge clk);
      #1;
      n_total++; if (fifo_pop !== 1'b0) $display("FAIL rst_pop: got %b want 0", fifo_pop); else n_pass++;
      n_total++; if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", m_valid); else n_pass++;
      n_total++; if (m_data !== 8'h00) $display("FAIL rst_data: got %h want 00", m_data); else n_pass++;
      n_total++; if (m_last !== 1'b0) $display("FAIL rst_last: got %b want 0", m_last); else n_pass++;
      n_total++; if (pop_b !== 1'b0) $display("FAIL rst_pop_b: got %b want 0", pop_b); else n_pass++;
      fq.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         n_total++; if (s_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", s_valid); else n_pass++;
         n_total++; if (s_pop !== 1'b0) $display("FAIL idle_pop: got %b want 0", s_pop); else n_pass++;
         n_total++; if (s_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", s_busy); else n_pass++;
         n_total++; if (s_cnt !== 16'd0) $display("FAIL idle_count: got %0d want 0", s_cnt); else n_pass++;
      end
   endtask

   task automatic test_single();
      logic [31:0] w;
      logic [15:0] c0;
      w  = 32'hDDCCBBAA;
      c0 = word_count;
      blog.delete(); plog.delete();
      fq.push_back(w);
      repeat (7) cycle();
      n_total++; if (plog.size() != 1) $display("FAIL single_pops: got %0d want 1", plog.size()); else n_pass++;
      n_total++; if (blog.size() != 4) $display("FAIL single_beats: got %0d want 4", blog.size()); else n_pass++;
      if (plog.size() == 1 && blog.size() == 4)
         for (int k = 0; k < 4; k++) begin
            n_total++; if (blog[k].d !== 8'((w >> (8 * k)) & 32'hFF)) $display("FAIL single_data%0d: got %h want %h", k, blog[k].d, 8'((w >> (8 * k)) & 32'hFF)); else n_pass++;
            n_total++; if (blog[k].c != plog[0] + 1 + k) $display("FAIL single_cyc%0d: got %0d want %0d", k, blog[k].c, plog[0] + 1 + k); else n_pass++;
            n_total++; if (blog[k].l !== (k == 3)) $display("FAIL single_last%0d: got %b want %b", k, blog[k].l, (k == 3)); else n_pass++;
         end
      #1;
      n_total++; if (word_count !== c0 + 16'd1) $display("FAIL single_count: got %0d want %0d", word_count, c0 + 16'd1); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      blog.delete(); plog.delete();
      fq.push_back(32'h04030201);
      fq.push_back(32'h08070605);
      repeat (11) cycle();
      n_total++; if (plog.size() != 2) $display("FAIL b2b_pops: got %0d want 2", plog.size()); else n_pass++;
      n_total++; if (blog.size() != 8) $display("FAIL b2b_beats: got %0d want 8", blog.size()); else n_pass++;
      if (plog.size() == 2 && blog.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            n_total++; if (blog[k].d !== 8'(k + 1)) $display("FAIL b2b_data%0d: got %h want %h", k, blog[k].d, 8'(k + 1)); else n_pass++;
            n_total++; if (blog[k].c != blog[0].c + k) $display("FAIL b2b_gap%0d: got %0d want %0d", k, blog[k].c, blog[0].c + k); else n_pass++;
            n_total++; if (blog[k].l !== (k == 3 || k == 7)) $display("FAIL b2b_last%0d: got %b", k, blog[k].l); else n_pass++;
         end
         n_total++; if (plog[1] != blog[3].c) $display("FAIL b2b_pop2: got %0d want %0d", plog[1], blog[3].c); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b[8];
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h88, 8'h77, 8'h66, 8'h55};
      blog.delete(); plog.delete();
      fq.push_back(32'hDDCCBBAA);
      fq.push_back(32'h55667788);
      m_ready = 1'b1;
      cycle();
      cycle();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_total++; if (s_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, s_valid); else n_pass++;
         n_total++; if (s_data !== 8'hBB) $display("FAIL bp_data%0d: got %h want bb", i, s_data); else n_pass++;
         n_total++; if (s_pop !== 1'b0) $display("FAIL bp_pop%0d: got %b want 0", i, s_pop); else n_pass++;
      end
      m_ready = 1'b1;
      repeat (9) cycle();
      n_total++; if (blog.size() != 8) $display("FAIL bp_beats: got %0d want 8", blog.size()); else n_pass++;
      if (blog.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            n_total++; if (blog[k].d !== exp_b[k]) $display("FAIL bp_seq%0d: got %h want %h", k, blog[k].d, exp_b[k]); else n_pass++;
         end
         n_total++; if (blog[1].c != blog[0].c + 4) $display("FAIL bp_stall: got %0d want %0d", blog[1].c, blog[0].c + 4); else n_pass++;
      end
   endtask

   task automatic test_enable();
      int en_cyc;
      blog.delete(); plog.delete();
      fq.push_back(32'h44332211);
      fq.push_back(32'h88776655);
      enable = 1'b1;
      cycle();
      cycle();
      enable = 1'b0;
      repeat (5) cycle();
      n_total++; if (plog.size() != 1) $display("FAIL en_nopop: got %0d pops want 1", plog.size()); else n_pass++;
      n_total++; if (blog.size() != 4) $display("FAIL en_finish: got %0d beats want 4", blog.size()); else n_pass++;
      if (blog.size() == 4) begin
         n_total++; if (blog[3].d !== 8'h44 || blog[3].l !== 1'b1) $display("FAIL en_last: got %h/%b want 44/1", blog[3].d, blog[3].l); else n_pass++;
      end
      enable = 1'b1;
      en_cyc = cyc;
      cycle();
      n_total++; if (s_pop !== 1'b1) $display("FAIL en_repop: got %b want 1", s_pop); else n_pass++;
      if (plog.size() == 2) begin
         n_total++; if (plog[1] != en_cyc) $display("FAIL en_popcyc: got %0d want %0d", plog[1], en_cyc); else n_pass++;
      end
      repeat (5) cycle();
      n_total++; if (blog.size() != 8) $display("FAIL en_word2: got %0d beats want 8", blog.size()); else n_pass++;
      if (blog.size() == 8) begin
         n_total++; if (blog[4].d !== 8'h55) $display("FAIL en_first2: got %h want 55", blog[4].d); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      #1;
      n_total++; if (word_count !== 16'd0) $display("FAIL rm_clear: got %0d want 0", word_count); else n_pass++;
      @(negedge clk);
      blog.delete(); plog.delete();
      fq.push_back(32'hDDCCBBAA);
      fq.push_back(32'h0D0C0B0A);
      cycle();
      cycle();
      cycle();
      fifo_empty = 1'b0;
      fifo_data  = fq[0];
      reset = 1'b1;
      #1;
      n_total++; if (m_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", m_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (word_count !== 16'd0) $display("FAIL rm_count: got %0d want 0", word_count); else n_pass++;
      n_total++; if (fifo_pop !== 1'b0) $display("FAIL rm_pop: got %b want 0", fifo_pop); else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      blog.delete(); plog.delete();
      repeat (7) cycle();
      n_total++; if (blog.size() != 4) $display("FAIL rm_beats: got %0d want 4", blog.size()); else n_pass++;
      if (blog.size() == 4)
         for (int k = 0; k < 4; k++) begin
            n_total++; if (blog[k].d !== 8'(8'h0A + k)) $display("FAIL rm_data%0d: got %h want %h", k, blog[k].d, 8'(8'h0A + k)); else n_pass++;
         end
      n_total++; if (s_cnt !== 16'd1) $display("FAIL rm_count2: got %0d want 1", s_cnt); else n_pass++;
   endtask

   task automatic test_msb_first();
      logic [31:0] w;
      logic [7:0]  e;
      w = 32'h11223344;
      en_b = 1'b1;
      ready_b = 1'b1;
      empty_b = 1'b0;
      data_b = w;
      #1;
      n_total++; if (pop_b !== 1'b1) $display("FAIL msb_pop: got %b want 1", pop_b); else n_pass++;
      @(negedge clk);
      empty_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         e = 8'((w >> (8 * (3 - k))) & 32'hFF);
         #1;
         n_total++; if (valid_b !== 1'b1 || mdata_b !== e) $display("FAIL msb_beat%0d: got %b/%h want 1/%h", k, valid_b, mdata_b, e); else n_pass++;
         n_total++; if (last_b !== (k == 3)) $display("FAIL msb_last%0d: got %b want %b", k, last_b, (k == 3)); else n_pass++;
         @(negedge clk);
      end
      #1;
      n_total++; if (valid_b !== 1'b0 || count_b !== 16'd1) $display("FAIL msb_done: got %b/%0d want 0/1", valid_b, count_b); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0]  cur[$];
      logic [15:0] mcnt;
      logic        e_pop, e_valid, e_last;
      logic [7:0]  e_data;
      logic [31:0] head;
      mcnt = word_count;
      for (int i = 0; i < 500; i++) begin
         m_ready = ($urandom_range(0, 9) < 7);
         enable  = ($urandom_range(0, 9) < 8);
         if (fq.size() < 3 && $urandom_range(0, 3) == 0) fq.push_back($urandom);
         head    = (fq.size() != 0) ? fq[0] : 32'h0;
         e_valid = (cur.size() != 0);
         e_data  = e_valid ? cur[0] : 8'h00;
         e_last  = (cur.size() == 1);
         e_pop   = (fq.size() != 0) && enable &&
                   (cur.size() == 0 || (m_ready && cur.size() == 1));
         cycle();
         n_total++; if (s_pop !== e_pop) $display("FAIL rnd_pop@%0d: got %b want %b", cyc, s_pop, e_pop); else n_pass++;
         n_total++; if (s_valid !== e_valid || s_busy !== e_valid) $display("FAIL rnd_valid@%0d: got %b/%b want %b", cyc, s_valid, s_busy, e_valid); else n_pass++;
         if (e_valid) begin
            n_total++; if (s_data !== e_data || s_last !== e_last) $display("FAIL rnd_beat@%0d: got %h/%b want %h/%b", cyc, s_data, s_last, e_data, e_last); else n_pass++;
         end
         n_total++; if (s_cnt !== mcnt) $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, s_cnt, mcnt); else n_pass++;
         if (e_valid && m_ready) begin
            void'(cur.pop_front());
            if (cur.size() == 0) mcnt++;
         end
         if (e_pop) begin
            cur.delete();
            for (int k = 0; k < 4; k++) cur.push_back(8'((head >> (8 * k)) & 32'hFF));
         end
      end
      m_ready = 1'b1;
      enable  = 1'b1;
      repeat (20) cycle();
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      m_ready = 1'b1;
      fifo_empty = 1'b1;
      fifo_data = 32'h0;
      en_b = 1'b0;
      empty_b = 1'b1;
      data_b = 32'h0;
      ready_b = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_enable();
      test_reset_mid();
      test_msb_first();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
